// File: rtl/ram_line_fetch.sv
// ram_line_fetch: streams a run of 16-bit SRAM words from an arbiter port into
// a small FIFO that a downstream consumer drains with a valid/ready handshake.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   start, base_adr,    begin a fetch of `count` words from `base_adr` (idle only)
//   count
//   abort               cancel the fetch and flush the FIFO
//   busy, done          fetch in progress / one-cycle completion pulse
//   m_adr, m_req,       arbiter read port (request held until granted by m_ack,
//   m_ack, m_rdata      data valid with the ack)
//   m_write, m_sel,     constant read-only controls
//   m_wdata
//   out_valid,          FIFO head handshake; pop when out_valid && out_ready
//   out_data, out_ready
module ram_line_fetch #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [17:0] base_adr,
  input  logic [9:0]  count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [17:0] m_adr,
  output logic        m_req,
  input  logic        m_ack,
  output logic        m_write,
  output logic [1:0]  m_sel,
  input  logic [15:0] m_rdata,
  output logic [15:0] m_wdata,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready
);

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t          state, state_d;
  logic [AW-1:0]   adr, adr_d;
  logic [CW-1:0]   rem, rem_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [OW-1:0]   occ, occ_d;
  logic            push, pop, flush;
  logic            room;

  // Next-state, request and FIFO bookkeeping
  always_comb begin
    state_d = state;
    adr_d   = adr;
    rem_d   = rem;
    req_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    flush   = abort;
    // Acks are only honoured while a request is outstanding in FETCH
    push    = (state == S_FETCH) && req_q && m_ack && !abort;
    pop     = (occ != '0) && out_ready && !abort;

    occ_d = occ;
    if (flush) begin
      occ_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   occ_d = occ + OW'(1);
        2'b01:   occ_d = occ - OW'(1);
        default: occ_d = occ;
      endcase
    end

    // Request only with two free slots left: the registered request may still
    // be granted once more before it can drop
    room = (occ_d <= OW'(DEPTH - 2));

    if (abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      rem_d   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (count == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_FETCH;
              adr_d   = base_adr;
              rem_d   = count;
              busy_d  = 1'b1;
              req_d   = room;
            end
          end
        end
        S_FETCH: begin
          if (push) begin
            adr_d = adr + AW'(1);
            rem_d = rem - CW'(1);
          end
          if (rem_d == '0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            req_d = room;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Fetch control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr    <= '0;
      rem    <= '0;
      req_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      adr    <= adr_d;
      rem    <= rem_d;
      req_q  <= req_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      occ <= occ_d;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= m_rdata;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign m_adr     = adr;
  assign m_req     = req_q;
  assign m_write   = 1'b0;
  assign m_sel     = 2'b11;
  assign m_wdata   = '0;
  assign out_valid = (occ != '0);
  assign out_data  = mem[rd_ptr];

endmodule

// File: tb/tb_ram_line_fetch.sv
// Bench for ram_line_fetch: directed fetch table, corner-case sequences and a
// randomized run, all checked against a queue-based model of the fetch.
module tb_ram_line_fetch;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [17:0] base_adr = '0;
  logic [9:0]  count = '0;
  logic        abort = 1'b0;
  logic        busy, done, m_req, m_write, out_valid;
  logic [17:0] m_adr;
  logic [1:0]  m_sel;
  logic        m_ack = 1'b0;
  logic [15:0] m_rdata = '0;
  logic [15:0] m_wdata, out_data;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  ram_line_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .count(count),
    .abort(abort), .busy(busy), .done(done), .m_adr(m_adr), .m_req(m_req),
    .m_ack(m_ack), .m_write(m_write), .m_sel(m_sel), .m_rdata(m_rdata),
    .m_wdata(m_wdata), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: words sitting in the FIFO, plus the fetch still owed
  logic [15:0] mq[$];
  bit          mb_busy = 0;
  int          mb_rem = 0;
  logic [17:0] mb_adr = '0;
  bit          mb_done = 0;

  // Arbiter / observation controls
  bit          arb_en = 1;
  int          arb_pct = 100;
  bit          rand_data = 0;
  bit          force_ack = 0;
  bit          last_ack = 0;
  logic [15:0] got[$];
  int          done_cnt = 0;

  typedef struct {
    logic [17:0] base;
    logic [9:0]  cnt;
    int          rdy_pct;
    int          exp_n;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mb_busy = 0;
    mb_rem  = 0;
    mb_adr  = '0;
    mb_done = 0;
  endtask

  // One clock: compare at the falling edge, drive inputs, advance the model
  task automatic cycle(input bit st, input logic [17:0] b, input logic [9:0] c,
                       input bit ab, input bit rdy);
    bit exp_req, push_m, pop_m;
    @(negedge clk);
    exp_req = mb_busy && (mb_rem != 0) && (mq.size() <= DEPTH - 2);
    chk("busy", busy, mb_busy);
    chk("done", done, mb_done);
    chk("m_req", m_req, exp_req);
    chk("out_valid", out_valid, mq.size() != 0);
    if (exp_req) chk("m_adr", m_adr, mb_adr);
    if (out_valid && mq.size() != 0) chk("out_data", out_data, mq[0]);
    if (done) done_cnt++;

    start = st; base_adr = b; count = c; abort = ab; out_ready = rdy;
    m_ack = force_ack || (arb_en && m_req && !last_ack && ($urandom_range(99) < arb_pct));
    m_rdata = rand_data ? 16'($urandom) : m_adr[15:0];
    if (out_valid && rdy) got.push_back(out_data);

    push_m = exp_req && m_ack && !ab;
    pop_m  = rdy && (mq.size() != 0);
    if (ab) begin
      model_clear();
    end else begin
      mb_done = 0;
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back(m_rdata);
        mb_adr = mb_adr + 18'd1;
        mb_rem--;
        if (mb_rem == 0) begin
          mb_busy = 0;
          mb_done = 1;
        end
      end else if (!mb_busy && st) begin
        if (c == 0) mb_done = 1;
        else begin
          mb_busy = 1;
          mb_rem  = int'(c);
          mb_adr  = b;
        end
      end
    end
    last_ack = m_ack;
  endtask

  // Run idle cycles until the model has nothing left to fetch or deliver
  task automatic drain(input int rdy_pct, input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      cycle(0, '0, '0, 0, $urandom_range(99) < rdy_pct);
      if (!mb_busy && mq.size() == 0 && !mb_done) begin
        ok = 1;
        break;
      end
    end
    chk("drain_timeout", ok, 1);
  endtask

  // Assert reset now (asynchronously), check outputs, release on a falling edge
  task automatic do_reset();
    rst = 1'b0;
    start = 0; abort = 0; out_ready = 0; m_ack = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_m_adr", m_adr, 0);
    model_clear();
    m_ack = 1'b1;
    m_rdata = 16'hDEAD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_ack = 1'b0;
    chk("rst_ack_ignored", out_valid, 0);
    chk("rst_req_held", m_req, 0);
    rst = 1'b1;
    last_ack = 0;
  endtask

  initial begin
    vec_t tbl[4];
    int bad;
    bit ok;
    logic [17:0] b37;
    tbl[0] = '{18'h00100, 10'd4,  100, 4,  16'h0100, 16'h0103};
    tbl[1] = '{18'h3FFFE, 10'd4,  100, 4,  16'hFFFE, 16'h0001};
    tbl[2] = '{18'h00000, 10'd0,  100, 0,  16'h0000, 16'h0000};
    tbl[3] = '{18'h12345, 10'd17, 50,  17, 16'h2345, 16'h2355};

    #3;
    do_reset();
    chk("tie_m_write", m_write, 0);
    chk("tie_m_sel", m_sel, 2'b11);
    chk("tie_m_wdata", m_wdata, 0);

    // Directed fetch table, arbiter granting every second cycle, rdata = adr
    arb_en = 1; arb_pct = 100; rand_data = 0;
    for (int t = 0; t < 4; t++) begin
      got.delete();
      done_cnt = 0;
      cycle(1, tbl[t].base, tbl[t].cnt, 0, 1);
      drain(tbl[t].rdy_pct, 400);
      chk("tbl_words", got.size(), tbl[t].exp_n);
      if (tbl[t].exp_n > 0) begin
        chk("tbl_first", got[0], tbl[t].exp_first);
        chk("tbl_last", got[got.size()-1], tbl[t].exp_last);
      end
      chk("tbl_done_once", done_cnt, 1);
      chk("tbl_busy_after", busy, 0);
    end

    // Back-pressure: fill the FIFO, stall, then drain 40 words in order
    got.delete();
    done_cnt = 0;
    b37 = 18'h01000;
    cycle(1, b37, 10'd40, 0, 0);
    repeat (60) cycle(0, '0, '0, 0, 0);
    chk("stall_m_req", m_req, 0);
    chk("stall_busy", busy, 1);
    chk("stall_valid", out_valid, 1);
    drain(100, 400);
    chk("bp_words", got.size(), 40);
    bad = 0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] != 16'(b37 + 18'(i))) bad++;
    chk("bp_order", bad, 0);
    chk("bp_done_once", done_cnt, 1);

    // Abort while requesting; the ack that follows must be dropped
    got.delete();
    done_cnt = 0;
    arb_en = 0;
    cycle(1, 18'h00200, 10'd3, 0, 1);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_req) begin ok = 1; break; end
      cycle(0, '0, '0, 0, 1);
    end
    chk("abort_req_seen", ok, 1);
    cycle(0, '0, '0, 1, 1);
    force_ack = 1;
    cycle(0, '0, '0, 0, 1);
    force_ack = 0;
    cycle(0, '0, '0, 0, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done_cnt, 0);
    arb_en = 1;
    got.delete();
    done_cnt = 0;
    cycle(1, 18'h00300, 10'd2, 0, 1);
    drain(100, 200);
    chk("post_abort_words", got.size(), 2);
    if (got.size() == 2) begin
      chk("post_abort_w0", got[0], 16'h0300);
      chk("post_abort_w1", got[1], 16'h0301);
    end
    chk("post_abort_done", done_cnt, 1);

    // Abort and start together: start is dropped
    cycle(1, 18'h00400, 10'd5, 1, 1);
    cycle(0, '0, '0, 0, 1);
    chk("abort_start_busy", busy, 0);
    chk("abort_start_req", m_req, 0);

    // Reset mid-fetch with five words buffered
    got.delete();
    cycle(1, 18'h02000, 10'd20, 0, 0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (mq.size() == 5) begin ok = 1; break; end
      cycle(0, '0, '0, 0, 0);
    end
    chk("rst_fill_reached", ok, 1);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", out_valid, 1);
    do_reset();
    got.delete();
    done_cnt = 0;
    cycle(1, 18'h00777, 10'd1, 0, 1);
    drain(100, 100);
    chk("post_rst_words", got.size(), 1);
    if (got.size() == 1) chk("post_rst_word", got[0], 16'h0777);
    chk("post_rst_done", done_cnt, 1);

    // Randomized traffic against the model
    rand_data = 1;
    arb_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 6, 18'($urandom), 10'($urandom_range(0, 24)),
            $urandom_range(199) == 0, $urandom_range(99) < 60);
    end
    drain(100, 800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
